// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the IF/ID front-end controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: controller state encoding (also exported on ctrl_state for debug)
// and the JALR opcode plus a small matcher for front ends that decode it locally.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    STALL     = 2'd1,
    FLUSH     = 2'd2,
    JALR_WAIT = 2'd3
  } ctrl_state_e;

  localparam logic [6:0] OPC_JALR = 7'b1100111;

  function automatic logic is_jalr_opc(input logic [6:0] opc);
    return opc == OPC_JALR;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter used for the front-end performance counters.
// Latency: value reflects inc one cycle later (registered).
// Backpressure: none; holds at all-ones instead of wrapping.
//
// Ports: clk, rst (sync, active-high), inc (count enable), value (current count).
module sat_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  logic [CNT_W-1:0] value_q;
  logic [CNT_W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (inc && (value_q != '1)) begin
      value_d = value_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/pipe_ctrl.sv
// IF/ID front-end sequencer: PC/IF-ID write enables, decoder valid, redirect and flush.
// Latency: enables/redirect are combinational from state + inputs (0 cycles); state on posedge.
// Backpressure: dec_stall freezes PC and IF/ID the same cycle; JALR holds fetch until EX redirects.
//
// Ports: clk, rst (sync, active-high); dec_stall, id_is_jalr, ex_redirect, ex_target in;
// pc_we, ifid_we, id_valid, redirect, redirect_pc, ctrl_state out; stall_cycles,
// flush_cycles perf counters; watchdog_err (sticky until rst).
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int MAX_STALL    = 15,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_stall,
  input  logic             id_is_jalr,
  input  logic             ex_redirect,
  input  logic [XLEN-1:0]  ex_target,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             id_valid,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles,
  output logic             watchdog_err
);

  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
  localparam int RL_W = $clog2(MAX_STALL + 1);

  localparam logic [FC_W-1:0] FLUSH_INIT    = FC_W'(FLUSH_CYCLES);
  localparam logic [FC_W-1:0] FLUSH_RESTART = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [FC_W-1:0] FLUSH_LAST    = FC_W'(1);
  localparam logic [RL_W-1:0] RUN_MAX       = RL_W'(MAX_STALL);

  ctrl_state_e     state_q, state_d;
  logic [FC_W-1:0] cnt_q, cnt_d;
  logic [RL_W-1:0] run_q, run_d;
  logic            wd_q, wd_d;

  // Output decode and next-state. Priority: ex_redirect > dec_stall > id_is_jalr.
  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    id_valid    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    state_d     = state_q;
    cnt_d       = cnt_q;

    if (rst) begin
      // Everything stays quiet; the flops take their reset values below.
    end else if (ex_redirect) begin
      redirect    = 1'b1;
      redirect_pc = ex_target;
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      // The redirect cycle itself is the first squashed slot.
      if (FLUSH_RESTART == '0) begin
        state_d = RUN;
      end else begin
        state_d = FLUSH;
        cnt_d   = FLUSH_RESTART;
      end
    end else begin
      case (state_q)
        FLUSH: begin
          pc_we   = 1'b1;
          ifid_we = 1'b1;
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == FLUSH_LAST) begin
            state_d = RUN;
          end
        end
        RUN, STALL: begin
          // RUN and STALL drive identical outputs; they differ only for debug visibility.
          id_valid = 1'b1;
          pc_we    = !dec_stall;
          ifid_we  = !dec_stall;
          if (dec_stall) begin
            state_d = STALL;
          end else if (id_is_jalr) begin
            state_d = JALR_WAIT;
          end else begin
            state_d = RUN;
          end
        end
        JALR_WAIT: begin
          // Fetch held until EX resolves the jump target.
        end
        default: begin
          state_d = FLUSH;
          cnt_d   = FLUSH_INIT;
        end
      endcase
    end
  end

  // Stall watchdog. The RUN cycle in which dec_stall first freezes fetch already
  // belongs to the frozen run, so any pc_we=0 cycle out of reset extends it.
  always_comb begin
    run_d = run_q;
    wd_d  = wd_q;
    if (pc_we) begin
      run_d = '0;
    end else begin
      if (run_q != RUN_MAX) begin
        run_d = run_q + 1'b1;
      end
      if (run_d == RUN_MAX) begin
        wd_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FLUSH;
      cnt_q   <= FLUSH_INIT;
      run_q   <= '0;
      wd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      wd_q    <= wd_d;
    end
  end

  logic stall_inc;
  logic flush_inc;

  assign stall_inc = !rst && !pc_we;
  assign flush_inc = !rst && (redirect || (state_q == FLUSH));

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .value (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .value (flush_cycles)
  );

  assign ctrl_state   = state_q;
  assign watchdog_err = wd_q;

endmodule
